// File: rtl/apb3_pkg.sv
// apb3_pkg: shared FSM encoding, slot geometry and response codes for the APB3 slot decoder
package apb3_pkg;
  localparam int NUM_SLOTS = 16;
  localparam int SLOT_W = 4;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;
  localparam logic RSP_OKAY = 1'b0;
  localparam logic RSP_ERROR = 1'b1;
endpackage

// File: rtl/apb3_slot_decoder_timeout_if.sv
// apb3_slot_decoder_timeout_if: bridge-side APB3 transfer plus the fanned-out slave slot bus
interface apb3_slot_decoder_timeout_if import apb3_pkg::*; #(
  parameter int APB_DWIDTH = 32,
  parameter int SLOT_LSB = 12
);
  logic PSEL;
  logic PENABLE;
  logic PWRITE;
  logic [SLOT_LSB+3:0] PADDR;
  logic [APB_DWIDTH-1:0] PWDATA;
  logic [APB_DWIDTH-1:0] PRDATA;
  logic PREADY;
  logic PSLVERR;
  logic [NUM_SLOTS-1:0] PSELS;
  logic [SLOT_LSB-1:0] PADDRS;
  logic PWRITES;
  logic PENABLES;
  logic [APB_DWIDTH-1:0] PWDATAS;
  logic [NUM_SLOTS*APB_DWIDTH-1:0] PRDATAS;
  logic [NUM_SLOTS-1:0] PREADYS;
  logic [NUM_SLOTS-1:0] PSLVERRS;
  modport slave (
    input PSEL, PENABLE, PWRITE, PADDR, PWDATA, PRDATAS, PREADYS, PSLVERRS,
    output PRDATA, PREADY, PSLVERR, PSELS, PADDRS, PWRITES, PENABLES, PWDATAS
  );
  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PRDATAS, PREADYS, PSLVERRS,
    input PRDATA, PREADY, PSLVERR, PSELS, PADDRS, PWRITES, PENABLES, PWDATAS
  );
endinterface

// File: rtl/apb3_timeout_monitor.sv
// apb3_timeout_monitor: access-cycle counter, timeout compare and sticky first-timeout status
module apb3_timeout_monitor import apb3_pkg::*; #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_setup,
  input  logic i_wait,
  input  logic [SLOT_W-1:0] i_slot,
  input  logic i_clr,
  output logic o_timeout,
  output logic o_flag,
  output logic [SLOT_W-1:0] o_slot
);
  logic [7:0] r_cnt;
  logic r_flag;
  logic [SLOT_W-1:0] r_slot;
  assign o_timeout = (TIMEOUT != 0) && i_wait && (r_cnt == 8'(TIMEOUT - 1));
  assign o_flag = r_flag;
  assign o_slot = r_slot;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_flag <= 1'b0;
      r_slot <= '0;
    end else begin
      if (i_setup) r_cnt <= '0;
      else if (i_wait && r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
      // a coincident clear lets the new timeout overwrite the kept slot
      if (o_timeout) begin
        r_flag <= 1'b1;
        if (!r_flag || i_clr) r_slot <= i_slot;
      end else if (i_clr) begin
        r_flag <= 1'b0;
        r_slot <= '0;
      end
    end
  end
endmodule

// File: rtl/apb3_slot_decoder_timeout.sv
// apb3_slot_decoder_timeout: decodes a bridge APB3 transfer onto 16 slots with error and timeout responses
module apb3_slot_decoder_timeout import apb3_pkg::*; #(
  parameter int APB_DWIDTH = 32,
  parameter int SLOT_LSB = 12,
  parameter logic [NUM_SLOTS-1:0] SLOT_EN = 16'hFFFF,
  parameter int TIMEOUT = 64
) (
  input  logic HCLK,
  input  logic HRESETN,
  apb3_slot_decoder_timeout_if.slave bus,
  input  logic TO_CLR,
  output logic TO_FLAG,
  output logic [SLOT_W-1:0] TO_SLOT
);
  logic [0:0] r_state;
  logic [SLOT_W-1:0] r_slot;
  logic [SLOT_W-1:0] w_live_slot;
  logic [SLOT_W-1:0] w_slot;
  logic w_en;
  logic w_setup;
  logic w_access;
  logic w_wait;
  logic w_timeout;
  logic [APB_DWIDTH-1:0] w_rdata;
  assign w_live_slot = bus.PADDR[SLOT_LSB +: SLOT_W];
  assign w_setup = bus.PSEL && r_state == IDLE;
  assign w_access = bus.PSEL && r_state == ACCESS;
  // the address slot field is only honoured in the setup cycle
  assign w_slot = r_state == ACCESS ? r_slot : w_live_slot;
  assign w_en = SLOT_EN[w_slot];
  assign w_rdata = bus.PRDATAS[w_slot*APB_DWIDTH +: APB_DWIDTH];
  assign w_wait = w_access && w_en && !bus.PREADYS[w_slot];
  assign bus.PSELS = (bus.PSEL && w_en) ? NUM_SLOTS'(1) << w_slot : '0;
  assign bus.PREADY = w_access && (!w_en || w_timeout || bus.PREADYS[w_slot]);
  assign bus.PSLVERR = w_access ? ((!w_en || w_timeout) ? RSP_ERROR : bus.PSLVERRS[w_slot]) : RSP_OKAY;
  assign bus.PRDATA = (w_access && w_en && !w_timeout) ? w_rdata : '0;
  assign bus.PADDRS = bus.PADDR[SLOT_LSB-1:0];
  assign bus.PWRITES = bus.PWRITE;
  assign bus.PENABLES = bus.PENABLE;
  assign bus.PWDATAS = bus.PWDATA;
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      r_state <= IDLE;
      r_slot <= '0;
    end else begin
      if (w_setup) r_slot <= w_live_slot;
      r_state <= (w_setup || (w_access && !bus.PREADY)) ? ACCESS : IDLE;
    end
  end
  apb3_timeout_monitor #(.TIMEOUT(TIMEOUT)) u_mon (
    .clk(HCLK),
    .rst_n(HRESETN),
    .i_setup(w_setup),
    .i_wait(w_wait),
    .i_slot(w_slot),
    .i_clr(TO_CLR),
    .o_timeout(w_timeout),
    .o_flag(TO_FLAG),
    .o_slot(TO_SLOT)
  );
endmodule

// File: tb/tb_apb3_slot_decoder_timeout.sv
// tb_apb3_slot_decoder_timeout: vector table plus corner sequences, checked through a per-cycle scoreboard
module tb_apb3_slot_decoder_timeout;
  import apb3_pkg::*;
  localparam logic [15:0] EN = 16'h7FFF;
  localparam int TO = 4;
  logic HCLK = 1'b0;
  logic HRESETN;
  logic TO_CLR;
  logic TO_FLAG;
  logic [3:0] TO_SLOT;
  apb3_slot_decoder_timeout_if #(.APB_DWIDTH(32), .SLOT_LSB(12)) bus ();
  apb3_slot_decoder_timeout #(.APB_DWIDTH(32), .SLOT_LSB(12), .SLOT_EN(EN), .TIMEOUT(TO)) dut (
    .HCLK(HCLK),
    .HRESETN(HRESETN),
    .bus(bus),
    .TO_CLR(TO_CLR),
    .TO_FLAG(TO_FLAG),
    .TO_SLOT(TO_SLOT)
  );
  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [3:0] slot;
    logic wr;
    logic [11:0] off;
    logic [31:0] wd;
    logic [31:0] rd;
    int waits;
    logic serr;
    bit clr;
  } vec_t;
  typedef struct {
    string name;
    logic [15:0] psels;
    logic rdy;
    logic err;
    logic [31:0] data;
    logic [11:0] paddrs;
    logic wr;
    logic [31:0] wd;
    logic en;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[7];
  logic [15:0] en_v;
  int tests = 0;
  int fails = 0;
  logic m_flag = 1'b0;
  logic [3:0] m_slot = 4'd0;

  task automatic check(input string n, input logic [127:0] act, input logic [127:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, req);
    end
  endtask

  task automatic push(input string n, input logic [15:0] ps, input logic r, input logic e,
                      input logic [31:0] d, input logic [11:0] pa, input logic wr,
                      input logic [31:0] wd, input logic en);
    exp_t x;
    x = '{n, ps, r, e, d, pa, wr, wd, en};
    sb.push_back(x);
  endtask

  task automatic pop_check();
    exp_t x;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard: no expectation queued");
    end else begin
      x = sb.pop_front();
      check(x.name,
            {bus.PSELS, bus.PREADY, bus.PSLVERR, bus.PRDATA, bus.PADDRS, bus.PWRITES, bus.PWDATAS, bus.PENABLES},
            {x.psels, x.rdy, x.err, x.data, x.paddrs, x.wr, x.wd, x.en});
    end
  endtask

  task automatic check_status(input string n);
    check(n, {TO_FLAG, TO_SLOT}, {m_flag, m_slot});
  endtask

  task automatic fill_slaves(input logic [3:0] s, input logic [31:0] rd);
    for (int n = 0; n < 16; n++) bus.PRDATAS[n*32 +: 32] = 32'h1111_1111 * n;
    bus.PRDATAS[s*32 +: 32] = rd;
    // other slots look ready and erroring so a wrong mux selection shows up
    bus.PREADYS = ~(16'd1 << s);
    bus.PSLVERRS = ~(16'd1 << s);
  endtask

  task automatic xfer(input vec_t v);
    logic [15:0] oh;
    logic r, e, t;
    logic [31:0] d;
    int k;
    bit done;
    oh = en_v[v.slot] ? (16'd1 << v.slot) : 16'd0;
    @(posedge HCLK); #1;
    bus.PSEL = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE = v.wr;
    bus.PADDR = {v.slot, v.off};
    bus.PWDATA = v.wd;
    fill_slaves(v.slot, v.rd);
    push("setup", oh, 1'b0, 1'b0, 32'h0, v.off, v.wr, v.wd, 1'b0);
    @(negedge HCLK); pop_check();
    k = 0;
    done = 1'b0;
    while (!done) begin
      @(posedge HCLK); #1;
      k++;
      bus.PENABLE = 1'b1;
      bus.PADDR[15:12] = v.slot ^ 4'hF;
      bus.PREADYS[v.slot] = k > v.waits;
      bus.PSLVERRS[v.slot] = (k > v.waits) && v.serr;
      t = en_v[v.slot] && k <= v.waits && k == TO;
      if (!en_v[v.slot] || t) {r, e, d} = {1'b1, 1'b1, 32'h0};
      else if (k <= v.waits) {r, e, d} = {1'b0, 1'b0, v.rd};
      else {r, e, d} = {1'b1, v.serr, v.rd};
      TO_CLR = t && v.clr;
      push("access", oh, r, e, d, v.off, v.wr, v.wd, 1'b1);
      @(negedge HCLK); pop_check();
      if (t) begin
        if (!m_flag || v.clr) m_slot = v.slot;
        m_flag = 1'b1;
      end
      done = r;
    end
    @(posedge HCLK); #1;
    bus.PSEL = 1'b0;
    bus.PENABLE = 1'b0;
    TO_CLR = 1'b0;
    @(negedge HCLK);
    check("psels_after", {112'h0, bus.PSELS}, 128'h0);
    check_status("status_after");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t hv;
    en_v = EN;
    HRESETN = 1'b0;
    TO_CLR = 1'b0;
    bus.PSEL = 1'b0;
    bus.PENABLE = 1'b0;
    bus.PWRITE = 1'b0;
    bus.PADDR = '0;
    bus.PWDATA = '0;
    bus.PRDATAS = '0;
    bus.PREADYS = '0;
    bus.PSLVERRS = '0;
    vecs[0] = '{4'd3,  1'b1, 12'h010, 32'h1234_5678, 32'hCAFE_0003, 0,   1'b0, 1'b0};
    vecs[1] = '{4'd5,  1'b0, 12'h044, 32'h0,         32'hDEAD_BEEF, 3,   1'b0, 1'b0};
    vecs[2] = '{4'd15, 1'b0, 12'h100, 32'h0,         32'h5555_AAAA, 0,   1'b0, 1'b0};
    vecs[3] = '{4'd9,  1'b0, 12'h008, 32'h0,         32'h9999_0009, 100, 1'b0, 1'b0};
    vecs[4] = '{4'd2,  1'b1, 12'hFFC, 32'hA0A0_0202, 32'h2222_0002, 100, 1'b0, 1'b0};
    vecs[5] = '{4'd11, 1'b0, 12'h0C0, 32'h0,         32'hBBBB_000B, 100, 1'b0, 1'b1};
    vecs[6] = '{4'd0,  1'b0, 12'h004, 32'h0,         32'h0000_5A5A, 1,   1'b1, 1'b0};

    @(negedge HCLK);
    check("reset_outputs", {bus.PSELS, bus.PREADY, bus.PSLVERR, bus.PRDATA}, 128'h0);
    check_status("reset_status");
    @(posedge HCLK); #1 HRESETN = 1'b1;

    for (int i = 0; i < 7; i++) xfer(vecs[i]);

    // plain sticky clear
    @(posedge HCLK); #1 TO_CLR = 1'b1;
    @(posedge HCLK); #1 TO_CLR = 1'b0;
    m_flag = 1'b0;
    m_slot = 4'd0;
    @(negedge HCLK); check_status("to_clr");

    // coincident clear and timeout with the flag already clear
    hv = '{4'd13, 1'b0, 12'h020, 32'h0, 32'hD0D0_000D, 100, 1'b0, 1'b1};
    xfer(hv);

    // PENABLE with no setup cycle acts as a setup
    @(posedge HCLK); #1;
    bus.PSEL = 1'b1;
    bus.PENABLE = 1'b1;
    bus.PWRITE = 1'b0;
    bus.PWDATA = '0;
    bus.PADDR = {4'd10, 12'hABC};
    fill_slaves(4'd10, 32'h0BAD_F00D);
    bus.PREADYS = 16'h0400;
    bus.PSLVERRS = 16'h0;
    push("no_setup_first", 16'h0400, 1'b0, 1'b0, 32'h0, 12'hABC, 1'b0, 32'h0, 1'b1);
    @(negedge HCLK); pop_check();
    @(posedge HCLK); #1;
    push("no_setup_access", 16'h0400, 1'b1, 1'b0, 32'h0BAD_F00D, 12'hABC, 1'b0, 32'h0, 1'b1);
    @(negedge HCLK); pop_check();
    @(posedge HCLK); #1 bus.PSEL = 1'b0; bus.PENABLE = 1'b0;

    // PSEL dropped mid-access aborts the transfer
    @(posedge HCLK); #1;
    bus.PSEL = 1'b1;
    bus.PADDR = {4'd4, 12'h040};
    fill_slaves(4'd4, 32'h4444_0004);
    bus.PREADYS = 16'h0;
    @(posedge HCLK); #1 bus.PENABLE = 1'b1;
    push("abort_wait", 16'h0010, 1'b0, 1'b0, 32'h4444_0004, 12'h040, 1'b0, 32'h0, 1'b1);
    @(negedge HCLK); pop_check();
    @(posedge HCLK); #1 bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    push("abort_drop", 16'h0, 1'b0, 1'b0, 32'h0, 12'h040, 1'b0, 32'h0, 1'b0);
    @(negedge HCLK); pop_check();
    check_status("abort_status");
    hv = '{4'd4, 1'b0, 12'h040, 32'h0, 32'h4444_0004, 1, 1'b0, 1'b0};
    xfer(hv);

    // asynchronous reset in the middle of a wait-stated read, with the sticky flag set
    hv = '{4'd1, 1'b0, 12'h001, 32'h0, 32'h1111_0001, 100, 1'b0, 1'b0};
    xfer(hv);
    @(posedge HCLK); #1;
    bus.PSEL = 1'b1;
    bus.PADDR = {4'd6, 12'h066};
    fill_slaves(4'd6, 32'h6666_0006);
    bus.PREADYS = 16'h0;
    @(posedge HCLK); #1 bus.PENABLE = 1'b1;
    @(posedge HCLK); #1;
    @(negedge HCLK); #1;
    HRESETN = 1'b0;
    bus.PREADYS[6] = 1'b1;
    #1;
    m_flag = 1'b0;
    m_slot = 4'd0;
    check("reset_mid_pready", {127'h0, bus.PREADY}, 128'h0);
    check_status("reset_mid_status");
    bus.PSEL = 1'b0;
    bus.PENABLE = 1'b0;
    #1 check("reset_mid_psels", {112'h0, bus.PSELS}, 128'h0);
    @(posedge HCLK); #1 HRESETN = 1'b1;
    hv = '{4'd6, 1'b0, 12'h066, 32'h0, 32'h6666_0006, 2, 1'b0, 1'b0};
    xfer(hv);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
